oam_dma_controller: RTL
=======================

Name: oam_dma_controller

Overview:
- Implements the $FF46 OAM DMA transfer. It sits between the CPU bus and the memory controller's CPU-side port.
- When the CPU writes page P to $FF46, the block takes the bus and copies DMA_LENGTH bytes from {P',8'h00} into OAM_BASE, one read cycle then one write cycle per byte.
- The CPU is locked out of memory for the whole transfer.
- While idle, the block is a transparent passthrough.

Parameters:
- DMA_LENGTH, 160, number of bytes per transfer (1..256).
- OAM_BASE, 16'hFE00, destination base address.
- START_DELAY, 1, idle cycles between trigger and first read (0..15).

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- A_cpu  input  16  CPU address.
- Di_cpu  input  8  CPU write data.
- Do_cpu  output  8  read data returned to the CPU.
- rd_cpu_n  input  1  CPU read strobe, active-low.
- wr_cpu_n  input  1  CPU write strobe, active-low.
- A_mem  output  16  address to the memory controller.
- Do_mem  output  8  write data to the memory controller.
- Di_mem  input  8  read data from the memory controller.
- rd_mem_n  output  1  read strobe to the memory controller, active-low.
- wr_mem_n  output  1  write strobe to the memory controller, active-low.
- dma_active  output  1  high while a transfer owns the bus.

Behaviour:
- Clock and reset: one clock (clock). reset is asynchronous, active-low.
- Reset values: state=IDLE, idx=0, data_q=8'h00, src_page=8'h00, wr_q=1, dma_active=0. Bus outputs are in passthrough.
- Trigger:
  - Registered edge detect: trigger when wr_cpu_n==0 && wr_q==1 && A_cpu==16'hFF46. wr_q <= wr_cpu_n every cycle.
  - On trigger: src_page <= Di_cpu, idx <= 0, state <= DELAY (READ if START_DELAY==0), dma_active <= 1 on the same edge.
- Source remap: eff_page = src_page >= 8'hE0 ? src_page - 8'h20 : src_page. Read address = {eff_page, idx}.
- FSM:
  - IDLE: stays idle until trigger.
  - DELAY: counts START_DELAY cycles, then goes to READ.
  - READ: A_mem={eff_page,idx}, rd_mem_n=0, wr_mem_n=1. data_q <= Di_mem at the end of the cycle. Goes to WRITE.
  - WRITE: A_mem=OAM_BASE+idx, Do_mem=data_q, wr_mem_n=0, rd_mem_n=1.
    - If idx==DMA_LENGTH-1: state <= IDLE, dma_active <= 0.
    - Else: idx <= idx+1, state <= READ.
- Timing: total busy time is START_DELAY + 2*DMA_LENGTH cycles (321 with defaults). idx is 8 bits; it never wraps within a transfer.
- IDLE passthrough (combinational): A_mem=A_cpu, Do_mem=Di_cpu, rd_mem_n=rd_cpu_n, wr_mem_n=wr_cpu_n. The $FF46 write is also forwarded.
- Do_cpu, IDLE: returns src_page when A_cpu==16'hFF46, else Di_mem.
- CPU during DMA (DELAY/READ/WRITE):
  - CPU strobes are not forwarded.
  - Do_cpu=8'hFF, except src_page when A_cpu==16'hFF46.
  - CPU writes are dropped, except the $FF46 trigger.
  - In DELAY, the bus is idle: A_mem=16'h0000, both strobes high.
- Restart: a trigger during DMA restarts immediately. The new page is taken, idx=0, state=DELAY, dma_active stays 1. A partially copied OAM is not rolled back.
- Simultaneous events: a trigger on the same edge as the final WRITE wins, and the transfer restarts.
- Reset mid-transfer: the FSM aborts on the reset assertion edge and the bus returns to passthrough. No further writes are issued.

Optional Feature:
- Macro: OAM_DMA_DONE_EN.
- Defined: adds output dma_done (1 bit, reset 0). It is a one-cycle high pulse on the cycle after the final WRITE completes. It does not pulse if the transfer was restarted or reset before completion.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package (gb_mem_pkg), holding:
  - state encoding: IDLE, DELAY, READ, WRITE
  - constants: DMA_REG_ADDR=16'hFF46, ECHO_PAGE_LO=8'hE0, ECHO_OFFSET=8'h20, OAM_BASE default
  - the 8'hFF open-bus value
- No sub-module; the FSM and bus mux fit in a single module.

Test Plan:
- Idle passthrough: CPU reads $C123 with Di_mem=8'h5A, and writes $C000=8'h33. Expect Do_cpu=8'h5A, and A_mem/Do_mem/wr_mem_n mirror the CPU.
- Full transfer: preload $C000-$C09F with i^8'hA5, then write $FF46=8'hC0. Expect dma_active high for exactly 321 cycles, and 160 writes to $FE00-$FE9F with matching data, each preceded by a read of $C0xx.
- Lockout: during DMA the CPU reads $C000 and reads $FF46. Expect 8'hFF and 8'hC0 respectively. A CPU write to $C000 produces no wr_mem_n pulse with A_mem=$C000.
- Echo remap: write $FF46=8'hE1. Expect read addresses $C100-$C19F, and a $FF46 readback of 8'hE1.
- Restart: write $FF46=8'hC0, then at byte 50 write $FF46=8'hD0. Expect idx to restart at 0 with reads from $D000, and dma_active continuously high until the final write of $FE9F.
- Reset abort: assert reset at byte 10. Expect dma_active=0 immediately, passthrough bus, no further OAM writes, and (with OAM_DMA_DONE_EN) no dma_done pulse.

Source files
------------

// File: rtl/gb_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gb_mem_pkg
//  Description : Shared memory-map constants, DMA state encoding and helpers
//                for the Game Boy CPU-side memory path.
//  Revision    : 1.0 - initial release
// ============================================================================
package gb_mem_pkg;

    // DMA controller state encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DELAY = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    // Memory-map constants
    localparam logic [15:0] DMA_REG_ADDR     = 16'hFF46;
    localparam logic [7:0]  ECHO_PAGE_LO     = 8'hE0;
    localparam logic [7:0]  ECHO_OFFSET      = 8'h20;
    localparam logic [15:0] OAM_BASE_DEFAULT = 16'hFE00;

    // Value returned to the CPU when it cannot see the bus
    localparam logic [7:0]  OPEN_BUS         = 8'hFF;

    // Pages $E0-$FF alias work RAM at $C0-$DF (echo region)
    function automatic logic [7:0] remap_page(input logic [7:0] page);
        return (page >= ECHO_PAGE_LO) ? (page - ECHO_OFFSET) : page;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma_controller.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_controller
//  Description : $FF46 OAM DMA engine. Sits between the CPU bus and the
//                memory controller; transparent while idle, owns the bus and
//                copies DMA_LENGTH bytes from page P into OAM when triggered.
//                Optional macro OAM_DMA_DONE_EN adds a one-cycle dma_done
//                pulse after a transfer completes normally.
//  Revision    : 1.0 - initial release
// ============================================================================
module oam_dma_controller
    import gb_mem_pkg::*;
#(
    parameter int unsigned  DMA_LENGTH  = 160,
    parameter logic [15:0]  OAM_BASE    = OAM_BASE_DEFAULT,
    parameter int unsigned  START_DELAY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] A_cpu,
    input  logic [7:0]  Di_cpu,
    output logic [7:0]  Do_cpu,
    input  logic        rd_cpu_n,
    input  logic        wr_cpu_n,
    output logic [15:0] A_mem,
    output logic [7:0]  Do_mem,
    input  logic [7:0]  Di_mem,
    output logic        rd_mem_n,
    output logic        wr_mem_n,
    output logic        dma_active
`ifdef OAM_DMA_DONE_EN
    ,
    output logic        dma_done
`endif
);

    localparam logic [7:0] c_IDX_LAST   = 8'(DMA_LENGTH - 1);
    localparam logic [3:0] c_DELAY_LAST = 4'((START_DELAY == 0) ? 0 : (START_DELAY - 1));
    localparam logic [1:0] c_START_ST   = (START_DELAY == 0) ? S_READ : S_DELAY;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [7:0]  r_idx;
    logic [7:0]  r_data_q;
    logic [7:0]  r_src_page;
    logic        r_wr_q;
    logic [3:0]  r_delay_cnt;

    logic        w_trigger;
    logic        w_last;
    logic        w_reg_sel;
    logic [7:0]  w_eff_page;

    // Falling edge of the CPU write strobe aimed at the DMA register
    assign w_trigger  = !wr_cpu_n && r_wr_q && (A_cpu == DMA_REG_ADDR);
    assign w_last     = (r_idx == c_IDX_LAST);
    assign w_reg_sel  = (A_cpu == DMA_REG_ADDR);
    assign w_eff_page = remap_page(r_src_page);
    assign dma_active = (r_state != S_IDLE);

    // State register; an asserted reset aborts any transfer immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a trigger restarts from any state and wins over completion
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = S_IDLE;
            S_DELAY: w_next_state = (r_delay_cnt == c_DELAY_LAST) ? S_READ : S_DELAY;
            S_READ:  w_next_state = S_WRITE;
            S_WRITE: w_next_state = w_last ? S_IDLE : S_READ;
            default: w_next_state = S_IDLE;
        endcase
        if (w_trigger) begin
            w_next_state = c_START_ST;
        end
    end

    // Datapath: strobe history, source page, byte index, delay count and read latch
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_q      <= 1'b1;
            r_src_page  <= 8'h00;
            r_idx       <= 8'h00;
            r_data_q    <= 8'h00;
            r_delay_cnt <= 4'h0;
        end else begin
            r_wr_q <= wr_cpu_n;
            if (w_trigger) begin
                r_src_page  <= Di_cpu;
                r_idx       <= 8'h00;
                r_delay_cnt <= 4'h0;
            end else begin
                case (r_state)
                    S_DELAY: r_delay_cnt <= r_delay_cnt + 4'h1;
                    S_READ:  r_data_q    <= Di_mem;
                    S_WRITE: begin
                        if (!w_last) begin
                            r_idx <= r_idx + 8'h01;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Bus mux: passthrough while idle, DMA-driven cycles otherwise
    always_comb begin
        A_mem    = A_cpu;
        Do_mem   = Di_cpu;
        rd_mem_n = rd_cpu_n;
        wr_mem_n = wr_cpu_n;
        Do_cpu   = w_reg_sel ? r_src_page : Di_mem;
        case (r_state)
            S_IDLE: ;
            S_DELAY: begin
                A_mem    = 16'h0000;
                Do_mem   = 8'h00;
                rd_mem_n = 1'b1;
                wr_mem_n = 1'b1;
                Do_cpu   = w_reg_sel ? r_src_page : OPEN_BUS;
            end
            S_READ: begin
                A_mem    = {w_eff_page, r_idx};
                Do_mem   = 8'h00;
                rd_mem_n = 1'b0;
                wr_mem_n = 1'b1;
                Do_cpu   = w_reg_sel ? r_src_page : OPEN_BUS;
            end
            S_WRITE: begin
                A_mem    = OAM_BASE + {8'h00, r_idx};
                Do_mem   = r_data_q;
                rd_mem_n = 1'b1;
                wr_mem_n = 1'b0;
                Do_cpu   = w_reg_sel ? r_src_page : OPEN_BUS;
            end
            default: ;
        endcase
    end

`ifdef OAM_DMA_DONE_EN
    logic r_done;

    // Completion pulse: only a final WRITE not pre-empted by a new trigger
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_WRITE) && w_last && !w_trigger;
        end
    end

    assign dma_done = r_done;
`endif

endmodule
`default_nettype wire
